data_mem_req: RTL

- Consumer end of the data-side translated-address interface. Accepts one translated beat per handshake: physical address, uncached flag, exception flag/code and access info.
- Issues a single-outstanding request to the data bus/cache and aligns load data.
- Presents a writeback result (load data or exception with bad vaddr) to the memory pipeline stage.

---
 rtl/data_mem_req_pkg.sv | 19 +
 rtl/data_mem_req_if.sv | 55 +++++
 rtl/data_mem_req_mem_lane_align.sv | 45 ++++
 rtl/data_mem_req.sv | 122 ++++++++++++
 4 files changed

// File: rtl/data_mem_req_pkg.sv
// data_mem_req_pkg: size encodings, FSM state type and shared defaults for the data-side request block.
// Rev 1.0
`default_nettype none
package data_mem_req_pkg;
  localparam int EXCP_W_DEF = 7;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;
endpackage
`default_nettype wire

// File: rtl/data_mem_req_if.sv
// data_mem_req_if: translated-beat, bus and writeback interfaces; master drives valid/data.
// Rev 1.0
`default_nettype none
interface data_mem_trans_if import data_mem_req_pkg::*; #(parameter int EXCP_W = EXCP_W_DEF);
  logic              trans_valid;
  logic              trans_ready;
  logic              trans_fire;
  logic [31:0]       trans_paddr;
  logic [31:0]       trans_vaddr;
  logic              trans_uncached;
  logic              trans_excp;
  logic [EXCP_W-1:0] trans_excp_num;
  logic              op_store;
  logic [1:0]        op_size;
  logic              op_unsigned;
  logic [31:0]       op_wdata;

  modport master (output trans_valid, trans_paddr, trans_vaddr, trans_uncached, trans_excp,
                  trans_excp_num, op_store, op_size, op_unsigned, op_wdata,
                  input  trans_ready, trans_fire);
  modport slave  (input  trans_valid, trans_paddr, trans_vaddr, trans_uncached, trans_excp,
                  trans_excp_num, op_store, op_size, op_unsigned, op_wdata,
                  output trans_ready, trans_fire);
endinterface

interface data_mem_bus_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wdata;
  logic        req_uncached;
  logic        resp_valid;
  logic [31:0] resp_rdata;

  modport master (output req_valid, req_wr, req_size, req_addr, req_wstrb, req_wdata, req_uncached,
                  input  req_ready, resp_valid, resp_rdata);
  modport slave  (input  req_valid, req_wr, req_size, req_addr, req_wstrb, req_wdata, req_uncached,
                  output req_ready, resp_valid, resp_rdata);
endinterface

interface data_mem_wb_if import data_mem_req_pkg::*; #(parameter int EXCP_W = EXCP_W_DEF);
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_rdata;
  logic              wb_excp;
  logic [EXCP_W-1:0] wb_excp_num;
  logic [31:0]       wb_badv;

  modport master (output wb_valid, wb_rdata, wb_excp, wb_excp_num, wb_badv, input wb_ready);
  modport slave  (input  wb_valid, wb_rdata, wb_excp, wb_excp_num, wb_badv, output wb_ready);
endinterface
`default_nettype wire

// File: rtl/data_mem_req_mem_lane_align.sv
// mem_lane_align: combinational load-lane extraction/extension and store strobe/data replication.
// Rev 1.0
`default_nettype none
module mem_lane_align import data_mem_req_pkg::*; (
  input  wire logic [1:0]  i_size,
  input  wire logic [1:0]  i_off,
  input  wire logic        i_unsigned,
  input  wire logic [31:0] i_rdata,
  input  wire logic [31:0] i_wdata,
  output logic      [31:0] o_ld_data,
  output logic      [3:0]  o_wstrb,
  output logic      [31:0] o_wdata
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte    = i_rdata[7:0];
    w_half    = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_ld_data = i_rdata;
    o_wstrb   = 4'b1111;
    o_wdata   = i_wdata;
    case (i_off)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    // Size 3 is illegal and falls through to word handling.
    case (i_size)
      SZ_BYTE: begin
        o_ld_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        o_wstrb   = 4'b0001 << i_off;
        o_wdata   = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_ld_data = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_wstrb   = 4'b0011 << i_off;
        o_wdata   = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/data_mem_req.sv
// data_mem_req: single-outstanding data-side memory request engine with load alignment and writeback.
// Rev 1.0
`default_nettype none
module data_mem_req import data_mem_req_pkg::*; #(
  parameter bit UNC_STORE_WAIT = 1'b1,
  parameter int EXCP_W         = EXCP_W_DEF
) (
  input  wire logic         clk,
  input  wire logic         reset,
  input  wire logic         flush,
  data_mem_trans_if.slave   trans,
  data_mem_bus_if.master    bus,
  data_mem_wb_if.master     wb
);
  state_t            r_state, w_next;
  logic [31:0]       r_paddr;
  logic              r_store;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic              r_uncached;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_excp;
  logic [EXCP_W-1:0] r_excp_num;
  logic [31:0]       r_badv;

  logic              w_trans_ready;
  logic              w_fire;
  logic              w_req_to_wait;
  logic [31:0]       w_ld_data;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_st_wdata;

  assign w_trans_ready = ~flush & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & wb.wb_ready));
  assign w_fire        = trans.trans_valid & w_trans_ready;
  assign w_req_to_wait = ~r_store | (r_uncached & UNC_STORE_WAIT);

  mem_lane_align u_align (
    .i_size     (r_size),
    .i_off      (r_paddr[1:0]),
    .i_unsigned (r_unsigned),
    .i_rdata    (bus.resp_rdata),
    .i_wdata    (r_wdata),
    .o_ld_data  (w_ld_data),
    .o_wstrb    (w_wstrb),
    .o_wdata    (w_st_wdata)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_fire) w_next = trans.trans_excp ? ST_DONE : ST_REQ;
      ST_REQ: begin
        if (flush)              w_next = (bus.req_ready & w_req_to_wait) ? ST_DRAIN : ST_IDLE;
        else if (bus.req_ready) w_next = w_req_to_wait ? ST_WAIT : ST_DONE;
      end
      ST_WAIT: begin
        // A response landing with the flush retires the op; draining would wait forever.
        if (flush)               w_next = bus.resp_valid ? ST_IDLE : ST_DRAIN;
        else if (bus.resp_valid) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (flush)            w_next = ST_IDLE;
        else if (w_fire)      w_next = trans.trans_excp ? ST_DONE : ST_REQ;
        else if (wb.wb_ready) w_next = ST_IDLE;
      end
      ST_DRAIN: if (bus.resp_valid) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_paddr    <= '0;
      r_store    <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_uncached <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_excp     <= 1'b0;
      r_excp_num <= '0;
      r_badv     <= '0;
    end else if (w_fire) begin
      r_paddr    <= trans.trans_paddr;
      r_store    <= trans.op_store;
      r_size     <= trans.op_size;
      r_unsigned <= trans.op_unsigned;
      r_uncached <= trans.trans_uncached;
      r_wdata    <= trans.op_wdata;
      r_rdata    <= '0;
      r_excp     <= trans.trans_excp;
      r_excp_num <= trans.trans_excp ? trans.trans_excp_num : '0;
      r_badv     <= trans.trans_excp ? trans.trans_vaddr : '0;
    end else if ((r_state == ST_WAIT) && (w_next == ST_DONE) && !r_store) begin
      r_rdata    <= w_ld_data;
    end
  end

  assign trans.trans_ready = w_trans_ready;
  assign trans.trans_fire  = w_fire;

  assign bus.req_valid    = (r_state == ST_REQ);
  assign bus.req_wr       = r_store;
  assign bus.req_size     = r_size;
  assign bus.req_addr     = r_paddr;
  assign bus.req_wstrb    = bus.req_valid ? w_wstrb : 4'b0000;
  assign bus.req_wdata    = w_st_wdata;
  assign bus.req_uncached = r_uncached;

  assign wb.wb_valid    = (r_state == ST_DONE);
  assign wb.wb_rdata    = r_rdata;
  assign wb.wb_excp     = r_excp;
  assign wb.wb_excp_num = r_excp_num;
  assign wb.wb_badv     = r_badv;
endmodule
`default_nettype wire
